// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   SIZE_B / SIZE_H / SIZE_W : access-size encodings (funct3[1:0]); 2'b11 is illegal
//   dmem_state_t             : responder FSM states
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// Load-path lane extraction and extension for the data-memory responder.
//
// Ports:
//   word        in  32  full array word containing the addressed bytes
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size (SIZE_B / SIZE_H / SIZE_W, 2'b11 illegal)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   data        out 32  right-aligned, extended load value (0 for illegal size)
//   misaligned  out 1   half at odd offset or word at non-zero offset
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halves only come from an even offset; offset[1] picks the upper half.
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data       = 32'h0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                data       = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            SIZE_W: begin
                data       = word;
                misaligned = (offset != 2'b00);
            end
            default: begin
                // Illegal size is flagged by the responder, not here.
                data       = 32'h0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the core's load/store path.
// Accepts one byte/half/word request, waits WAIT_CYCLES, commits stores with
// byte-lane masking or reads and extends load data, then presents a response.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the owned array
//   WAIT_CYCLES  wait states between accept and response (0..7)
//
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   asynchronous, active-low reset
//   req_valid    in  1   request present
//   req_ready    out 1   responder can accept a request
//   req_write    in  1   1 = store, 0 = load
//   req_addr     in  32  byte address
//   req_wdata    in  32  right-aligned store data
//   req_size     in  2   funct3[1:0]
//   req_unsigned in  1   funct3[2], zero-extend loads
//   rsp_valid    out 1   response present
//   rsp_ready    in  1   core accepts the response
//   rsp_rdata    out 32  extended load data, 0 for stores and errors
//   rsp_err      out 1   misaligned, out-of-range or illegal-size request
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_t state;
    logic [2:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic [AW-1:0] word_idx;
    logic [31:0]   load_data;
    logic          misaligned;
    logic          access_err;
    logic          commit;
    logic          store_commit;
    logic [3:0]    lane_mask;
    logic [31:0]   store_lanes;

    assign word_idx = addr_q[AW+1:2];

    load_align u_load_align (
        .word        (mem[word_idx]),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data),
        .misaligned  (misaligned)
    );

    // The range check uses the full word address so that addresses beyond the
    // array never alias onto a valid word through the truncated index.
    assign access_err   = (size_q == 2'b11) || misaligned ||
                          ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign commit       = (state == WAIT) && (cnt == 3'd0);
    assign store_commit = commit && write_q && !access_err;

    // Replicate the right-aligned store data into every lane it could land in,
    // so the lane mask alone decides which bytes are written.
    always_comb begin
        lane_mask   = 4'b0000;
        store_lanes = wdata_q;
        case (size_q)
            SIZE_B: begin
                lane_mask   = 4'b0001 << addr_q[1:0];
                store_lanes = {4{wdata_q[7:0]}};
            end
            SIZE_H: begin
                lane_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            SIZE_W: begin
                lane_mask   = 4'b1111;
                store_lanes = wdata_q;
            end
            default: begin
                lane_mask   = 4'b0000;
                store_lanes = wdata_q;
            end
        endcase
    end

    // The array has no reset; a reset during WAIT kills store_commit via the
    // state register, so a pending store is simply dropped.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
                end
            end
        end
    end

    // A zero wait count still passes through WAIT for one edge, which is the
    // commit edge; this keeps latency at 1 + WAIT_CYCLES for every setting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        write_q    <= req_write;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        cnt        <= 3'(WAIT_CYCLES);
                        req_ready  <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= access_err;
                        rsp_rdata <= (write_q || access_err) ? 32'h0 : load_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. Three instances with WAIT_CYCLES of
// 1, 0 and 3 share clock and reset; only one of them has a transaction in
// flight at any time, so a single ordered queue of expected responses works.
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int W0 = 1;
    localparam int W1 = 0;
    localparam int W2 = 3;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_write    [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_applied;
    int   n_miss;
    time  last_accept;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) u_dut2 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : ((d == 1) ? W1 : W2);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: a response is consumed on the edge after a negedge that sees
    // valid && ready, so each handshake is compared exactly once.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && rsp_valid[i] && rsp_ready[i]) begin
                n_applied++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("[TB] FAIL unexpected_rsp dut%0d: got rdata=%h err=%b, expected none",
                             i, rsp_rdata[i], rsp_err[i]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dut != i || rsp_rdata[i] !== e.rdata || rsp_err[i] !== e.err) begin
                        n_miss++;
                        $display("[TB] FAIL rsp dut%0d: got rdata=%h err=%b, expected dut%0d rdata=%h err=%b",
                                 i, rsp_rdata[i], rsp_err[i], e.dut, e.rdata, e.err);
                    end
                end
            end
        end
    end

    // Holds req_valid until the instance accepts; leaves time at accept edge + 1.
    task automatic wait_accept(input int d);
        bit accepted;
        accepted = 1'b0;
        req_valid[d] = 1'b1;
        for (int k = 0; k < 50 && !accepted; k++) begin
            if (req_ready[d]) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[d] = 1'b0;
        last_accept = $time - 1;
        check_output("accept", {31'h0, accepted}, 32'h1);
    endtask

    task automatic issue(input int d, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   lat;
        e.dut   = d;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        req_write[d]    = wr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        wait_accept(d);
        lat = 0;
        for (int k = 1; k <= 50 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[d]) lat = k;
        end
        check_output("latency", 32'(lat), 32'(1 + wait_of(d)));
    endtask

    task automatic finish_rsp(input int d);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid[d]) done = 1'b1;
        end
        check_output("rsp_done", {31'h0, done}, 32'h1);
        check_output("req_ready_after_rsp", {31'h0, req_ready[d]}, 32'h1);
    endtask

    task automatic apply_stimulus(input int d, input logic wr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                  input logic exp_err);
        issue(d, wr, size, uns, addr, wdata, exp_rdata, exp_err);
        finish_rsp(d);
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check_output({tag, "_req_ready"}, {31'h0, req_ready[d]}, 32'h0);
        check_output({tag, "_rsp_valid"}, {31'h0, rsp_valid[d]}, 32'h0);
        check_output({tag, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
        check_output({tag, "_rsp_err"},   {31'h0, rsp_err[d]},   32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time t0;
        n_applied = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]    = 1'b0;
            req_write[i]    = 1'b0;
            req_addr[i]     = 32'h0;
            req_wdata[i]    = 32'h0;
            req_size[i]     = 2'b00;
            req_unsigned[i] = 1'b0;
            rsp_ready[i]    = 1'b1;
        end

        // Reset values and the first req_ready rise.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_outputs(i, "reset");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("req_ready_before_edge", {31'h0, req_ready[0]}, 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check_output("req_ready_first_edge", {31'h0, req_ready[i]}, 32'h1);

        // Word round-trip, WAIT_CYCLES = 1.
        apply_stimulus(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte/half extension over 0x8001F0FF.
        apply_stimulus(0, 1'b1, SIZE_W, 1'b0, 32'h20, 32'h8001F0FF, 32'h0, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_B, 1'b0, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_B, 1'b1, 32'h20, 32'h0, 32'h000000FF, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_H, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_H, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_B, 1'b0, 32'h21, 32'h0, 32'hFFFFFFF0, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_B, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_H, 1'b0, 32'h20, 32'h0, 32'hFFFFF0FF, 1'b0);

        // Errors: nothing written, follow-up loads see the original word.
        apply_stimulus(0, 1'b0, SIZE_H, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
        apply_stimulus(0, 1'b1, SIZE_W, 1'b0, 32'h22, 32'hCAFEBABE, 32'h0, 1'b1);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
        apply_stimulus(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        apply_stimulus(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b1);
        apply_stimulus(0, 1'b1, SIZE_W, 1'b0, 32'h1010, 32'h0BADF00D, 32'h0, 1'b1);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'h8001F0FF, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Lane masking: byte and half stores over a known word.
        apply_stimulus(0, 1'b1, SIZE_W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        apply_stimulus(0, 1'b1, SIZE_B, 1'b0, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        apply_stimulus(0, 1'b1, SIZE_H, 1'b0, 32'h22, 32'h12345A5A, 32'h0, 1'b0);
        apply_stimulus(0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'h5A5AAA44, 1'b0);

        // Backpressure: response held for 5 cycles with rsp_ready low.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output("bp_rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
            check_output("bp_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check_output("bp_req_ready", {31'h0, req_ready[0]}, 32'h0);
        end
        rsp_ready[0] = 1'b1;
        finish_rsp(0);

        // Throughput with WAIT_CYCLES = 0: one accept every 3 cycles.
        apply_stimulus(1, 1'b1, SIZE_W, 1'b0, 32'h100, 32'h01020304, 32'h0, 1'b0);
        t0 = last_accept;
        apply_stimulus(1, 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'h01020304, 1'b0);
        check_output("accept_spacing_1", 32'(last_accept - t0), 32'd30);
        t0 = last_accept;
        apply_stimulus(1, 1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 32'h00000001, 1'b0);
        check_output("accept_spacing_2", 32'(last_accept - t0), 32'd30);
        t0 = last_accept;
        apply_stimulus(1, 1'b0, SIZE_B, 1'b0, 32'h101, 32'h0, 32'h00000003, 1'b0);
        check_output("accept_spacing_3", 32'(last_accept - t0), 32'd30);

        // Reset mid-WAIT with WAIT_CYCLES = 3: the pending store is dropped.
        apply_stimulus(2, 1'b1, SIZE_W, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0);
        req_write[2]    = 1'b1;
        req_size[2]     = SIZE_W;
        req_unsigned[2] = 1'b0;
        req_addr[2]     = 32'h40;
        req_wdata[2]    = 32'h00000055;
        wait_accept(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(2, "mid_wait");
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs(2, "in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("req_ready_after_reset", {31'h0, req_ready[2]}, 32'h1);
        apply_stimulus(2, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0);

        repeat (2) @(posedge clk);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory-side end of the load/store path. Accepts one byte/half/word request at a time over a valid/ready handshake, inserts a fixed number of wait states, commits stores with byte-lane masking, and returns sign- or zero-extended load data over a second valid/ready handshake. It sits between the core's load/store path (driven by `load_enb`, `funct3` and the ALU address) and a word-organised RAM array it owns.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array. Valid byte addresses are 0 to 4*DEPTH_WORDS-1.
- `WAIT_CYCLES`, 1: wait states between accept and response, range 0 to 7.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  funct3[2]: zero-extend loads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  32  extended load data. 0 for stores and for errors.
- `rsp_err`  out  1  misaligned, out-of-range or illegal-size request.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, latch `write`, `addr`, `wdata`, `size` and `unsigned`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or go directly to commit when `WAIT_CYCLES` = 0.
- **WAIT:** decrement the counter each cycle. When the counter reaches 0, commit and go to RESP.
- **Commit (single edge):**
  - Error if any of: size = 11; half with `addr[0]` = 1; word with `addr[1:0]` != 0; `addr[31:2]` >= `DEPTH_WORDS`.
  - On error: no array write, `rsp_err` = 1, `rsp_rdata` = 0.
  - Store, no error: write only the selected lanes. Byte: lane `addr[1:0]`. Half: lanes {`addr[1]`,0} and {`addr[1]`,1}. Word: all 4 lanes. `rsp_rdata` = 0.
  - Load, no error: extract the lanes and sign-extend from bit 7 or 15, or zero-extend if `unsigned`. Register the result into `rsp_rdata`.
- **RESP:**
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_valid` && `rsp_ready`.
  - On that handshake, go to IDLE and clear `rsp_valid` and `rsp_err`.
- `req_ready` = 0 in WAIT and RESP. Requests presented then are not accepted, and the core must hold them.
- The array is not reset. Initial contents are undefined unless preloaded by the bench.

## Timing
- All outputs are registered.
- **Reset values:** `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, state = IDLE, counter = 0.
- `req_ready` rises on the first rising edge after `reset` deasserts.
- **Latency:** request accepted at edge N, so `rsp_valid` is high after edge N+1+`WAIT_CYCLES`. With W = `WAIT_CYCLES`, a store writes the array at edge N+1+W.
- **Throughput:** response handshake at edge M, so `req_ready` is high after edge M. The next accept is at earliest edge M+1. This gives at most one transaction per W+3 cycles when `rsp_ready` is held high.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely. No further request is accepted.
- **Reset during WAIT:** the pending store is discarded, with no array write. The FSM returns to IDLE and all outputs take their reset values.
- **Reset during RESP:** the response is dropped.

## Structure
- **Package `mem_pkg`:**
  - size encodings `SIZE_B` = 2'b00, `SIZE_H` = 2'b01, `SIZE_W` = 2'b10.
  - state typedef `dmem_state_t` {IDLE, WAIT, RESP}.
- **Sub-module `load_align`:** combinational. Takes word, `addr[1:0]`, size and unsigned. Produces the 32-bit extended value and `misaligned`.
- The store lane-mask generation and the FSM live in `dmem_responder`.

## Test plan
- **Word round-trip (`WAIT_CYCLES` = 1):** store word 0xDEADBEEF at 0x10, then load word at 0x10. Expect `rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0. `rsp_valid` rises exactly 2 cycles after each accept.
- **Byte/half extension:** with word 0x8001F0FF at 0x20:
  - load byte 0x20: 0xFFFFFFFF.
  - load byte unsigned 0x20: 0x000000FF.
  - load half 0x22: 0xFFFF8001.
  - load half unsigned 0x22: 0x00008001.
- **Lane masking:** store byte 0xAA at 0x21 over 0x11223344. A following word load returns 0x1122AA44.
- **Errors:** each of the following gives `rsp_err` = 1 and `rsp_rdata` = 0, and a follow-up load of 0x20 still returns the original word:
  - half load at 0x21.
  - word store at 0x22.
  - word load at 4*`DEPTH_WORDS`.
  - size 11.
- **Backpressure and throughput:** hold `rsp_ready` = 0 for 5 cycles. `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0. Release: `req_ready` = 1 the next cycle. With `WAIT_CYCLES` = 0, back-to-back loads complete one every 3 cycles.
- **Reset mid-WAIT (`WAIT_CYCLES` = 3):** accept a word store 0x55 to 0x40 and assert `reset` 1 cycle later. Outputs go to their reset values. A load of 0x40 after reset returns the pre-reset contents, not 0x55.
